// File: rtl/mul_share_sched_pkg.sv
// mul_share_sched_pkg: shared constants, requester IDs and pipeline tag record
package mul_share_sched_pkg;
  localparam int KYBER_Q = 3329;
  localparam int DW_DEF = 12;
  localparam int TW_DEF = 8;
  localparam int LAT_DEF = 4;
  localparam int FDEPTH_DEF = 8;
  typedef enum logic {REQ_NTT = 1'b0, REQ_PWM = 1'b1} req_id_e;
  typedef struct packed {
    logic valid;
    req_id_e id;
    logic [TW_DEF-1:0] tag;
  } pipe_tag_t;
endpackage

// File: rtl/mul_share_sched_ret_fifo.sv
// ret_fifo: first-word fall-through return FIFO with occupancy count
module ret_fifo #(
  parameter int W = 20,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic valid,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic rd;
  assign valid = count != '0;
  assign rd = pop && valid;
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(rd);
      count <= count + CW'(push) - CW'(rd);
    end
  end
  // a push into a full FIFO is only legal together with a pop
  overflow: assert property (@(posedge clk) disable iff (rst) !(push && !rd && count == CW'(DEPTH)));
endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin, credit-limited sharing of one non-stallable mod-q multiplier
module mul_share_sched
  import mul_share_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int LAT = LAT_DEF,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic r0_valid,
  output logic r0_ready,
  input  logic [DW-1:0] r0_a,
  input  logic [DW-1:0] r0_b,
  input  logic [TW-1:0] r0_tag,
  input  logic r1_valid,
  output logic r1_ready,
  input  logic [DW-1:0] r1_a,
  input  logic [DW-1:0] r1_b,
  input  logic [TW-1:0] r1_tag,
  output logic m_en,
  output logic [DW-1:0] m_a,
  output logic [DW-1:0] m_b,
  input  logic [DW-1:0] m_res,
  output logic o0_valid,
  input  logic o0_ready,
  output logic [DW-1:0] o0_res,
  output logic [TW-1:0] o0_tag,
  output logic o1_valid,
  input  logic o1_ready,
  output logic [DW-1:0] o1_res,
  output logic [TW-1:0] o1_tag,
  output logic busy
);
  localparam int CW = $clog2(FDEPTH + 1);
  logic [CW-1:0] cnt0, cnt1, fcnt0, fcnt1;
  logic elig0, elig1, g0, g1, prio1, pop0, pop1;
  pipe_tag_t iss, tail;
  pipe_tag_t pipe [LAT];
  logic [DW+TW-1:0] d0, d1;
  assign elig0 = r0_valid && (cnt0 < CW'(FDEPTH));
  assign elig1 = r1_valid && (cnt1 < CW'(FDEPTH));
  // prio1 set means r1 wins a tie because r0 was granted last
  assign g0 = elig0 && !(elig1 && prio1);
  assign g1 = elig1 && !(elig0 && !prio1);
  assign r0_ready = g0;
  assign r1_ready = g1;
  assign pop0 = o0_valid && o0_ready;
  assign pop1 = o1_valid && o1_ready;
  assign m_en = iss.valid;
  assign tail = pipe[LAT-1];
  assign busy = (cnt0 != '0) || (cnt1 != '0);
  assign {o0_res, o0_tag} = d0;
  assign {o1_res, o1_tag} = d1;
  always_ff @(posedge clk) begin
    if (reset) begin
      prio1 <= 1'b0;
      cnt0 <= '0;
      cnt1 <= '0;
      iss <= '0;
      m_a <= '0;
      m_b <= '0;
    end else begin
      if (g0 || g1) prio1 <= g0;
      cnt0 <= cnt0 + CW'(g0) - CW'(pop0);
      cnt1 <= cnt1 + CW'(g1) - CW'(pop1);
      iss <= '{valid: g0 || g1, id: g1 ? REQ_PWM : REQ_NTT, tag: g1 ? r1_tag : g0 ? r0_tag : '0};
      m_a <= g1 ? r1_a : g0 ? r0_a : '0;
      m_b <= g1 ? r1_b : g0 ? r0_b : '0;
    end
  end
  // tag record tracks the multiplier pipeline so it lines up with m_res
  always_ff @(posedge clk) begin
    pipe[0] <= reset ? '0 : iss;
    for (int i = 1; i < LAT; i++) pipe[i] <= reset ? '0 : pipe[i-1];
  end
  ret_fifo #(.W(DW + TW), .DEPTH(FDEPTH)) u_fifo0 (
    .clk(clk), .rst(reset), .push(tail.valid && tail.id == REQ_NTT), .din({m_res, tail.tag}),
    .pop(o0_ready), .valid(o0_valid), .dout(d0), .count(fcnt0)
  );
  ret_fifo #(.W(DW + TW), .DEPTH(FDEPTH)) u_fifo1 (
    .clk(clk), .rst(reset), .push(tail.valid && tail.id == REQ_PWM), .din({m_res, tail.tag}),
    .pop(o1_ready), .valid(o1_valid), .dout(d1), .count(fcnt1)
  );
  credit_cover: assert property (@(posedge clk) disable iff (reset) fcnt0 <= cnt0 && fcnt1 <= cnt1);
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: scoreboard bench with a delayed (a*b) mod 3329 multiplier model
module tb_mul_share_sched;
  localparam int DW = 12, TW = 8, LAT = 4, FDEPTH = 8, Q = 3329;
  logic clk = 0, reset = 1;
  logic r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [DW-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0, m_a, m_b, m_res = 0, o0_res, o1_res;
  logic [TW-1:0] r0_tag = 0, r1_tag = 0, o0_tag, o1_tag;
  logic m_en, o0_valid, o1_valid, o0_ready = 1, o1_ready = 1, busy;
  typedef struct {logic [DW-1:0] res; logic [TW-1:0] tag; int t;} exp_t;
  exp_t q0[$], q1[$];
  int n_cmp = 0, n_err = 0, cyc = 0, c0 = 0, c1 = 0, acc0 = 0, acc1 = 0;
  logic last1 = 1;
  logic exp_en = 0;
  logic [DW-1:0] exp_a = 0, exp_b = 0;
  logic [DW-1:0] dl [LAT];

  mul_share_sched dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
    .m_en(m_en), .m_a(m_a), .m_b(m_b), .m_res(m_res),
    .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_res(o0_res), .o0_tag(o0_tag),
    .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_res(o1_res), .o1_tag(o1_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // multiplier: result of an m_en cycle appears LAT cycles later, junk otherwise
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = m_en ? DW'((int'(m_a) * int'(m_b)) % Q) : DW'($urandom);
    m_res <= dl[LAT-1];
  end

  // monitor: arbitration rule, issue stage, result timing and ordering
  always @(negedge clk) begin
    logic e0, e1, x0, x1;
    exp_t h;
    cyc++;
    if (reset) begin
      q0.delete(); q1.delete();
      c0 = 0; c1 = 0; last1 = 1;
      exp_en = 0; exp_a = 0; exp_b = 0;
    end else begin
      e0 = r0_valid && c0 < FDEPTH;
      e1 = r1_valid && c1 < FDEPTH;
      x0 = e0 && (!e1 || last1);
      x1 = e1 && (!e0 || !last1);
      chk("r0_ready", r0_ready, x0);
      chk("r1_ready", r1_ready, x1);
      chk("m_en", m_en, exp_en);
      chk("m_a", m_a, exp_a);
      chk("m_b", m_b, exp_b);
      chk("busy", busy, c0 + c1 != 0);
      chk("o0_valid", o0_valid, q0.size() != 0 && q0[0].t <= cyc);
      chk("o1_valid", o1_valid, q1.size() != 0 && q1[0].t <= cyc);
      if (o0_valid && o0_ready) begin
        if (q0.size() == 0) chk("o0_extra", 1, 0);
        else begin
          h = q0.pop_front();
          chk("o0_res", o0_res, h.res);
          chk("o0_tag", o0_tag, h.tag);
          c0--;
        end
      end
      if (o1_valid && o1_ready) begin
        if (q1.size() == 0) chk("o1_extra", 1, 0);
        else begin
          h = q1.pop_front();
          chk("o1_res", o1_res, h.res);
          chk("o1_tag", o1_tag, h.tag);
          c1--;
        end
      end
      exp_en = 0; exp_a = 0; exp_b = 0;
      if (r0_valid && r0_ready) begin
        q0.push_back('{DW'((int'(r0_a) * int'(r0_b)) % Q), r0_tag, cyc + LAT + 2});
        c0++; acc0++; last1 = 0;
        exp_en = 1; exp_a = r0_a; exp_b = r0_b;
      end
      if (r1_valid && r1_ready) begin
        q1.push_back('{DW'((int'(r1_a) * int'(r1_b)) % Q), r1_tag, cyc + LAT + 2});
        c1++; acc1++; last1 = 1;
        exp_en = 1; exp_a = r1_a; exp_b = r1_b;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rnd();
    r0_a = DW'($urandom); r0_b = DW'($urandom); r0_tag = TW'($urandom);
    r1_a = DW'($urandom); r1_b = DW'($urandom); r1_tag = TW'($urandom);
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_m_en"}, m_en, 0);
    chk({p, "_m_a"}, m_a, 0);
    chk({p, "_m_b"}, m_b, 0);
    chk({p, "_o0_valid"}, o0_valid, 0);
    chk({p, "_o1_valid"}, o1_valid, 0);
    chk({p, "_o0_res"}, o0_res, 0);
    chk({p, "_o1_tag"}, o1_tag, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_r0_ready"}, r0_ready, 0);
    chk({p, "_r1_ready"}, r1_ready, 0);
  endtask

  task automatic drain();
    int k = 0;
    r0_valid = 0; r1_valid = 0; o0_ready = 1; o1_ready = 1;
    while ((busy || q0.size() != 0 || q1.size() != 0) && k < 300) begin
      step();
      k++;
    end
    chk("drain", k < 300, 1);
  endtask

  initial begin
    int n, s0, s1;
    step(3);
    reset = 0;
    chk_idle("rst");
    // single request on r0
    r0_valid = 1; r0_a = 1234; r0_b = 2345; r0_tag = 8'h11;
    step();
    r0_valid = 0;
    chk("t1_m_en", m_en, 1);
    n = 0;
    while (!o0_valid && n < 20) begin
      step();
      n++;
    end
    chk("t1_lat", n, LAT + 1);
    chk("t1_res", o0_res, 829);
    chk("t1_tag", o0_tag, 8'h11);
    drain();
    // both streaming, outputs always ready
    s0 = acc0; s1 = acc1;
    r0_valid = 1; r1_valid = 1;
    repeat (20) begin rnd(); step(); end
    chk("t2_r0_accepts", acc0 - s0, 10);
    chk("t2_r1_accepts", acc1 - s1, 10);
    drain();
    // r1 output blocked, r1 runs out of credit
    o1_ready = 0; r0_valid = 1; r1_valid = 1;
    s1 = acc1;
    repeat (20) begin rnd(); step(); end
    chk("t3_r1_full", acc1 - s1, FDEPTH);
    s0 = acc0;
    repeat (10) begin rnd(); step(); end
    chk("t3_r0_rate", acc0 - s0, 10);
    chk("t3_r1_hold", acc1 - s1, FDEPTH);
    o1_ready = 1;
    rnd(); step();
    o1_ready = 0;
    repeat (10) begin rnd(); step(); end
    chk("t3_r1_one_more", acc1 - s1, FDEPTH + 1);
    drain();
    // pop and accept together at FDEPTH-1 credits
    o0_ready = 0; r1_valid = 0; r0_valid = 1;
    s0 = acc0; n = 0;
    while (acc0 - s0 < FDEPTH - 1 && n < 50) begin rnd(); step(); n++; end
    chk("t4_fill", acc0 - s0, FDEPTH - 1);
    r0_valid = 0;
    step(LAT + 3);
    r0_valid = 1; o0_ready = 1;
    rnd(); step();
    o0_ready = 0;
    s0 = acc0;
    repeat (5) begin rnd(); step(); end
    chk("t4_one_more", acc0 - s0, 1);
    drain();
    // reset with three requests in flight
    r0_valid = 1; r1_valid = 1;
    repeat (2) begin rnd(); step(); end
    r1_valid = 0;
    rnd(); step();
    r0_valid = 0; reset = 1;
    step();
    reset = 0;
    chk_idle("t5");
    step(LAT + 3);
    chk("t5_late_o0", o0_valid, 0);
    chk("t5_late_o1", o1_valid, 0);
    chk("t5_busy", busy, 0);
    r0_valid = 1; r1_valid = 1;
    #1;
    chk("t5_r0_first", r0_ready, 1);
    chk("t5_r1_wait", r1_ready, 0);
    step();
    drain();
    // random traffic
    repeat (10000) begin
      r0_valid = $urandom_range(0, 99) < 60;
      r1_valid = $urandom_range(0, 99) < 60;
      o0_ready = $urandom_range(0, 99) < 70;
      o1_ready = $urandom_range(0, 99) < 45;
      rnd();
      step();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
